// File: rtl/xadc_demo_pkg.sv
// Shared constants and state encoding for the XADC scaler / BCD display path.
package xadc_demo_pkg;
  localparam int NUM_DIGITS  = 7;
  localparam int CODE_W      = 12;
  localparam int SCALE_MUL   = 250000;
  localparam int SCALE_SHIFT = 10;
  localparam int SAT_CODE    = 4093;
  localparam int PROD_W      = 30;
  localparam int RES_W       = 20;
  localparam int BCD_W       = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE, MUL, DABBLE, LOAD} state_t;
endpackage

// File: rtl/xadc_bcd_converter_if.sv
// Sample-in / digits-out bundle between the DRP read path and the digit driver.
interface xadc_bcd_converter_if;
  logic        sample_valid;
  logic [15:0] sample;
  logic        busy;
  logic        digits_valid;
  logic [3:0]  dig0;
  logic [3:0]  dig1;
  logic [3:0]  dig2;
  logic [3:0]  dig3;
  logic [3:0]  dig4;
  logic [3:0]  dig5;
  logic [3:0]  dig6;

  modport master (
    output sample_valid, sample,
    input  busy, digits_valid, dig0, dig1, dig2, dig3, dig4, dig5, dig6
  );

  modport slave (
    input  sample_valid, sample,
    output busy, digits_valid, dig0, dig1, dig2, dig3, dig4, dig5, dig6
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble: RES_W-bit binary to NUM_DIGITS BCD digits, one bit per clock.
module bin_to_bcd_seq
  import xadc_demo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [4:0] LAST_ITER = 5'(RES_W - 1);

  logic             running;
  logic [4:0]       iter_cnt;
  logic [RES_W-1:0] shift_p0;

  function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] v,
                                                  input logic             b);
    logic [BCD_W-1:0] a;
    a = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return {a[BCD_W-2:0], b};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      iter_cnt <= '0;
    end else if (start) begin
      running  <= 1'b1;
      iter_cnt <= 5'd1;
    end else if (running) begin
      iter_cnt <= iter_cnt + 5'd1;
      if (iter_cnt == LAST_ITER) running <= 1'b0;
    end
  end

  // Start edge performs the first iteration from a cleared register.
  always_ff @(posedge clk) begin
    if (start) begin
      bcd      <= dabble_step('0, bin[RES_W-1]);
      shift_p0 <= bin << 1;
    end else if (running) begin
      bcd      <= dabble_step(bcd, shift_p0[RES_W-1]);
      shift_p0 <= shift_p0 << 1;
    end
  end

  // High during the cycle whose closing edge completes the final iteration.
  assign done = running && (iter_cnt == LAST_ITER);

endmodule

// File: rtl/xadc_bcd_converter.sv
// Scales a 12-bit XADC code by 250000/1024 and converts it to 7 BCD digits, throttled.
// Optional feature macro: XADC_BCD_SAT_EN (codes >= SAT_CODE display 1.000000).
module xadc_bcd_converter
  import xadc_demo_pkg::*;
#(
  parameter int UPDATE_PERIOD = 10_000_000
) (
  input logic                  CLK100MHZ,
  input logic                  reset_in,
  xadc_bcd_converter_if.slave  bus
);

  localparam int               THR_W    = $clog2(UPDATE_PERIOD);
  localparam logic [3:0]       MUL_LAST = 4'(CODE_W - 1);
  localparam logic [BCD_W-1:0] SAT_BCD  = 28'h100_0000;

  state_t              state, state_nxt;
  logic [THR_W-1:0]    thr_cnt;
  logic                thr_tc;
  logic                armed;
  logic                accept;
  logic                sat_hit;
  logic                sat_sel;
  logic [3:0]          mul_cnt;
  logic [CODE_W-1:0]   code_p0;
  logic [PROD_W-1:0]   acc_p1;
  logic [PROD_W-1:0]   addend_p1;
  logic [PROD_W-1:0]   acc_sum_p1;
  logic [RES_W-1:0]    res_p1;
  logic                bcd_start;
  logic                bcd_done;
  logic [BCD_W-1:0]    bcd_p2;
  logic [BCD_W-1:0]    dig;
  logic                digits_valid;
  logic [3:0]          sample_unused;

  assign sample_unused = bus.sample[3:0];

`ifdef XADC_BCD_SAT_EN
  assign sat_hit = bus.sample[15:4] >= CODE_W'(SAT_CODE);
`else
  assign sat_hit = 1'b0;
`endif

  assign thr_tc = (thr_cnt == THR_W'(UPDATE_PERIOD - 1));
  assign accept = (state == IDLE) && bus.sample_valid && armed;

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = sat_hit ? LOAD : MUL;
      MUL:     if (mul_cnt == MUL_LAST) state_nxt = DABBLE;
      DABBLE:  if (bcd_done) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Throttle and handshake control; a terminal count beats a same-cycle acceptance.
  always_ff @(posedge CLK100MHZ) begin
    if (reset_in) begin
      thr_cnt      <= '0;
      armed        <= 1'b1;
      digits_valid <= 1'b0;
      bcd_start    <= 1'b0;
      mul_cnt      <= '0;
      sat_sel      <= 1'b0;
    end else begin
      thr_cnt      <= thr_tc ? '0 : thr_cnt + 1'b1;
      if (thr_tc)      armed <= 1'b1;
      else if (accept) armed <= 1'b0;
      digits_valid <= (state == LOAD);
      bcd_start    <= (state == MUL) && (mul_cnt == MUL_LAST);
      if (accept) begin
        mul_cnt <= '0;
        sat_sel <= sat_hit;
      end else if (state == MUL) begin
        mul_cnt <= mul_cnt + 4'd1;
      end
    end
  end

  // Stage p0 -> p1: one partial product per cycle, LSB of the code first.
  always_comb begin
    addend_p1  = code_p0[mul_cnt] ? (PROD_W'(SCALE_MUL) << mul_cnt) : '0;
    acc_sum_p1 = acc_p1 + addend_p1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (accept) begin
      code_p0 <= bus.sample[15:4];
      acc_p1  <= '0;
    end else if (state == MUL) begin
      acc_p1 <= acc_sum_p1;
      if (mul_cnt == MUL_LAST) res_p1 <= acc_sum_p1[SCALE_SHIFT +: RES_W];
    end
  end

  // Stage p1 -> p2: serial binary-to-BCD.
  bin_to_bcd_seq u_bcd (
    .clk   (CLK100MHZ),
    .rst   (reset_in),
    .start (bcd_start),
    .bin   (res_p1),
    .done  (bcd_done),
    .bcd   (bcd_p2)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (reset_in)            dig <= '0;
    else if (state == LOAD)  dig <= sat_sel ? SAT_BCD : bcd_p2;
  end

  assign bus.busy         = (state != IDLE);
  assign bus.digits_valid = digits_valid;
  assign bus.dig0         = dig[3:0];
  assign bus.dig1         = dig[7:4];
  assign bus.dig2         = dig[11:8];
  assign bus.dig3         = dig[15:12];
  assign bus.dig4         = dig[19:16];
  assign bus.dig5         = dig[23:20];
  assign bus.dig6         = dig[27:24];

endmodule

// File: tb/tb_xadc_bcd_converter.sv
// Directed bench for xadc_bcd_converter with a 64-cycle update throttle.
module tb_xadc_bcd_converter;

  logic clk = 1'b0;
  logic rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  xadc_bcd_converter_if bus();

  xadc_bcd_converter #(.UPDATE_PERIOD(64)) dut (
    .CLK100MHZ (clk),
    .reset_in  (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] digits();
    return {bus.dig6, bus.dig5, bus.dig4, bus.dig3, bus.dig2, bus.dig1, bus.dig0};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Holds the strobe until accepted, then times and checks the result.
  task automatic do_convert(input string name, input logic [15:0] s,
                            input logic [27:0] exp_bcd, input int exp_lat, input bit noise);
    int n;
    bit got;
    bit busy_ok;
    bus.sample = s;
    bus.sample_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.busy) begin got = 1; break; end
    end
    total_cnt++;
    if (!got) $display("FAIL %s_accept: busy=%0b required 1", name, bus.busy);
    else pass_cnt++;
    if (noise) bus.sample = 16'hFFF0;
    else       bus.sample_valid = 1'b0;
    n = 0; got = 0; busy_ok = 1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.digits_valid) begin got = 1; break; end
      if (!bus.busy) busy_ok = 0;
    end
    bus.sample_valid = 1'b0;
    if (!got) n = -1;
    total_cnt++;
    if (n !== exp_lat) $display("FAIL %s_latency: got %0d required %0d", name, n, exp_lat);
    else pass_cnt++;
    total_cnt++;
    if (busy_ok !== 1'b1 || bus.busy !== 1'b0)
      $display("FAIL %s_busy: held=%0b at_update=%0b required 1/0", name, busy_ok, bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (digits() !== exp_bcd) $display("FAIL %s_digits: got %h required %h", name, digits(), exp_bcd);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.digits_valid !== 1'b0) $display("FAIL %s_pulse: digits_valid=%0b required 0", name, bus.digits_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b required 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.digits_valid !== 1'b0) $display("FAIL reset_dv: got %0b required 0", bus.digits_valid);
    else pass_cnt++;
    total_cnt++;
    if (digits() !== 28'h0) $display("FAIL reset_digits: got %h required 0000000", digits());
    else pass_cnt++;
  endtask

  task automatic test_convert();
    do_convert("half",   16'h8000, 28'h0500000, 33, 0);
    do_convert("code1",  16'h0010, 28'h0000244, 33, 0);
    do_convert("c4092",  16'hFFC0, 28'h0999023, 33, 0);
    do_convert("c291",   16'h1230, 28'h0071044, 33, 0);
  endtask

  task automatic test_full_scale();
`ifdef XADC_BCD_SAT_EN
    do_convert("fs", 16'hFFF0, 28'h1000000, 1, 0);
`else
    do_convert("fs", 16'hFFF0, 28'h0999755, 33, 0);
`endif
  endtask

  task automatic test_throttle();
    int acc_edges[$];
    int dv_cnt;
    bit prev_busy;
    do_reset();
    bus.sample = 16'h0010;
    bus.sample_valid = 1'b1;
    dv_cnt = 0;
    prev_busy = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (bus.busy && !prev_busy) acc_edges.push_back(k);
      if (bus.digits_valid) dv_cnt++;
      prev_busy = bus.busy;
    end
    bus.sample_valid = 1'b0;
    total_cnt++;
    if (acc_edges.size() !== 5) $display("FAIL thr_accepts: got %0d required 5", acc_edges.size());
    else pass_cnt++;
    total_cnt++;
    if (dv_cnt !== 5) $display("FAIL thr_updates: got %0d required 5", dv_cnt);
    else pass_cnt++;
    for (int j = 0; j < acc_edges.size() && j < 5; j++) begin
      total_cnt++;
      if (acc_edges[j] !== 1 + 64*j)
        $display("FAIL thr_edge%0d: got %0d required %0d", j, acc_edges[j], 1 + 64*j);
      else pass_cnt++;
    end
    total_cnt++;
    if (digits() !== 28'h0000244) $display("FAIL thr_digits: got %h required 0000244", digits());
    else pass_cnt++;
    repeat (40) @(posedge clk);
  endtask

  task automatic test_tc_coincident();
    bit got;
    do_reset();
    repeat (63) @(posedge clk);
    #1;
    // Acceptance lands on the terminal-count edge; noise strobes while busy and armed.
    do_convert("tc", 16'h0010, 28'h0000244, 33, 1);
    bus.sample = 16'h8000;
    bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL tc_rearm: busy=%0b required 1", bus.busy);
    else pass_cnt++;
    bus.sample_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.digits_valid) begin got = 1; break; end
    end
    total_cnt++;
    if (!got || digits() !== 28'h0500000)
      $display("FAIL tc_rearm_digits: got %h (update=%0b) required 0500000", digits(), got);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    bit got;
    int dv_cnt;
    bus.sample = 16'h0010;
    bus.sample_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (bus.busy) begin got = 1; break; end
    end
    bus.sample_valid = 1'b0;
    total_cnt++;
    if (!got) $display("FAIL abort_accept: busy=%0b required 1", bus.busy);
    else pass_cnt++;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.busy !== 1'b0 || digits() !== 28'h0 || bus.digits_valid !== 1'b0)
      $display("FAIL abort_state: busy=%0b dv=%0b digits=%h required 0/0/0000000",
               bus.busy, bus.digits_valid, digits());
    else pass_cnt++;
    rst = 1'b0;
    dv_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.digits_valid) dv_cnt++;
    end
    total_cnt++;
    if (dv_cnt !== 0) $display("FAIL abort_no_update: got %0d required 0", dv_cnt);
    else pass_cnt++;
    do_convert("after_abort", 16'h0400, 28'h0015625, 33, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample = 16'h0000;
    test_reset();
    test_convert();
    test_full_scale();
    test_throttle();
    test_tc_coincident();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
